// File: rtl/vx_ti_pkg.sv
// Shared sizing helpers for the ray-tracing engine memory arbiter.
// The requester id sits above the local tag, so every width derives from NUM_REQS.
package vx_ti_pkg;

    localparam int TI_NUM_REQS        = 4;
    localparam int TI_ADDR_WIDTH      = 32;
    localparam int TI_DATA_WIDTH      = 256;
    localparam int TI_TAG_WIDTH       = 4;
    localparam int TI_MAX_OUTSTANDING = 2;

    // A single requester still carries a 1-bit id so the tag layout never collapses.
    function automatic int calc_rid_w(input int num_reqs);
        return (num_reqs > 1) ? $clog2(num_reqs) : 1;
    endfunction

    function automatic int calc_mtag_w(input int num_reqs, input int tag_width);
        return calc_rid_w(num_reqs) + tag_width;
    endfunction

    function automatic int calc_cnt_w(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/vx_ti_mem_arb_if.sv
// Generic N-lane read port: requests flow master->slave, responses slave->master.
// Used with N=NUM_REQS on the engine side and N=1 on the LSU side.
interface vx_ti_mem_arb_if #(
    parameter int N          = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int TAG_WIDTH  = 4
);
    logic [N-1:0]            req_valid;
    logic [N*ADDR_WIDTH-1:0] req_addr;
    logic [N*TAG_WIDTH-1:0]  req_tag;
    logic [N-1:0]            req_ready;

    logic [N-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic [TAG_WIDTH-1:0]    rsp_tag;
    logic [N-1:0]            rsp_ready;

    modport master (
        output req_valid, req_addr, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_addr, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/vx_ti_rr_arb.sv
// Round-robin grant over an eligibility vector; the pointer only moves on an actual grant
// and then points just past the winner.
module vx_ti_rr_arb
    import vx_ti_pkg::*;
#(
    parameter  int NUM_REQS = 4,
    localparam int RID_W    = calc_rid_w(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [NUM_REQS-1:0] elig,
    output logic [NUM_REQS-1:0] gnt,
    output logic [RID_W-1:0]    gnt_idx,
    output logic                gnt_any
);

    logic [RID_W-1:0] ptr_q, ptr_d;

    always_comb begin
        int j;
        // NOTE: every output gets a default before any branch, so no path leaves a latch behind.
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        ptr_d   = ptr_q;
        j       = 0;
        if (en) begin
            // Walk downwards so the candidate closest to the pointer is written last and wins.
            for (int k = NUM_REQS - 1; k >= 0; k--) begin
                j = int'(ptr_q) + k;
                if (j >= NUM_REQS) j = j - NUM_REQS;
                if (elig[j]) begin
                    gnt_any = 1'b1;
                    gnt_idx = RID_W'(j);
                end
            end
            if (gnt_any) begin
                gnt   = NUM_REQS'(1'b1) << gnt_idx;
                ptr_d = (int'(gnt_idx) == NUM_REQS - 1) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/vx_ti_mem_arb.sv
// Shares one LSU read port among NUM_REQS traversal engines: round-robin grant with
// per-engine credits, {rid, tag} on the way out and rid-based routing on the way back.
module vx_ti_mem_arb
    import vx_ti_pkg::*;
#(
    parameter int NUM_REQS        = TI_NUM_REQS,
    parameter int ADDR_WIDTH      = TI_ADDR_WIDTH,
    parameter int DATA_WIDTH      = TI_DATA_WIDTH,
    parameter int TAG_WIDTH       = TI_TAG_WIDTH,
    parameter int MAX_OUTSTANDING = TI_MAX_OUTSTANDING
) (
    input  logic            clk,
    input  logic            reset,
    vx_ti_mem_arb_if.slave  eng,
    vx_ti_mem_arb_if.master mem,
    output logic            idle,
    output logic            err_bad_rid
);

    localparam int RID_W  = calc_rid_w(NUM_REQS);
    localparam int MTAG_W = calc_mtag_w(NUM_REQS, TAG_WIDTH);
    localparam int CNT_W  = calc_cnt_w(MAX_OUTSTANDING);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [MTAG_W-1:0]     tag;
    } ti_mem_req_t;

    logic [NUM_REQS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    ti_mem_req_t                    req_q, req_d;
    logic                           mem_valid_q, mem_valid_d;
    logic                           err_q, err_d;

    logic                can_load;
    logic [NUM_REQS-1:0] elig, gnt, rsp_vec, rsp_fire;
    logic [RID_W-1:0]    gnt_idx, rsp_rid;
    logic                gnt_any, rid_ok;

    // Grants are suppressed during reset so req_ready reads 0 there.
    assign can_load = !mem_valid_q || mem.req_ready;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            elig[i] = eng.req_valid[i] && (int'(cnt_q[i]) < MAX_OUTSTANDING);
        end
    end

    vx_ti_rr_arb #(.NUM_REQS(NUM_REQS)) u_rr_arb (
        .clk     (clk),
        .reset   (reset),
        .en      (can_load && !reset),
        .elig    (elig),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign eng.req_ready = gnt;

    // Response demux: zero latency, routed purely by the rid field of the returning tag.
    always_comb begin
        rsp_rid       = mem.rsp_tag[MTAG_W-1 -: RID_W];
        rid_ok        = int'(rsp_rid) < NUM_REQS;
        rsp_vec       = '0;
        mem.rsp_ready = 1'b1;
        if (rid_ok) begin
            rsp_vec       = NUM_REQS'(mem.rsp_valid) << rsp_rid;
            mem.rsp_ready = eng.rsp_ready[rsp_rid];
        end
    end

    assign eng.rsp_valid = rsp_vec;
    assign eng.rsp_data  = mem.rsp_data;
    assign eng.rsp_tag   = mem.rsp_tag[TAG_WIDTH-1:0];
    assign rsp_fire      = rsp_vec & eng.rsp_ready;

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (gnt[i] && !rsp_fire[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (!gnt[i] && rsp_fire[i] && cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end

        mem_valid_d = mem_valid_q;
        req_d       = req_q;
        if (can_load) begin
            mem_valid_d = gnt_any;
            if (gnt_any) begin
                req_d.addr = eng.req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                req_d.tag  = {gnt_idx, eng.req_tag[int'(gnt_idx)*TAG_WIDTH +: TAG_WIDTH]};
            end
        end

        err_d = err_q || (mem.rsp_valid && !rid_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            mem_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mem_valid_q <= mem_valid_d;
            err_q       <= err_d;
        end
    end

    // NOTE: the payload register is qualified by mem_valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        req_q <= req_d;
    end

    assign mem.req_valid = mem_valid_q;
    assign mem.req_addr  = req_q.addr;
    assign mem.req_tag   = req_q.tag;

    assign idle        = (cnt_q == '0) && !mem_valid_q;
    assign err_bad_rid = err_q;

endmodule

// File: tb/tb_vx_ti_mem_arb.sv
// Self-checking bench: a 4-requester instance with a request scoreboard, plus a
// 3-requester instance for out-of-range rid handling and mid-operation reset.
module tb_vx_ti_mem_arb;

    logic clk = 1'b0;
    logic reset;
    logic idle4, err4, idle3, err3;

    always #5 clk = ~clk;

    vx_ti_mem_arb_if #(.N(4), .ADDR_WIDTH(32), .DATA_WIDTH(256), .TAG_WIDTH(4)) eng4 ();
    vx_ti_mem_arb_if #(.N(1), .ADDR_WIDTH(32), .DATA_WIDTH(256), .TAG_WIDTH(6)) mem4 ();
    vx_ti_mem_arb_if #(.N(3), .ADDR_WIDTH(32), .DATA_WIDTH(256), .TAG_WIDTH(4)) eng3 ();
    vx_ti_mem_arb_if #(.N(1), .ADDR_WIDTH(32), .DATA_WIDTH(256), .TAG_WIDTH(6)) mem3 ();

    vx_ti_mem_arb #(.NUM_REQS(4), .ADDR_WIDTH(32), .DATA_WIDTH(256), .TAG_WIDTH(4), .MAX_OUTSTANDING(2)) dut4 (
        .clk(clk), .reset(reset), .eng(eng4), .mem(mem4), .idle(idle4), .err_bad_rid(err4)
    );

    vx_ti_mem_arb #(.NUM_REQS(3), .ADDR_WIDTH(32), .DATA_WIDTH(256), .TAG_WIDTH(4), .MAX_OUTSTANDING(2)) dut3 (
        .clk(clk), .reset(reset), .eng(eng3), .mem(mem3), .idle(idle3), .err_bad_rid(err3)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [37:0] exp_q[$];
    logic [31:0] addr_a[4];
    logic [3:0]  tag_a[4];
    logic [37:0] sb_exp;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [3:0] t);
        addr_a[i] = a;
        tag_a[i]  = t;
        eng4.req_addr[i*32 +: 32] = a;
        eng4.req_tag[i*4 +: 4]    = t;
    endtask

    task automatic push_exp(input int i);
        exp_q.push_back({addr_a[i], 2'(i), tag_a[i]});
    endtask

    task automatic rsp4(input logic v, input int rid, input logic [3:0] t, input logic [255:0] d);
        mem4.rsp_valid = v;
        mem4.rsp_tag   = {2'(rid), t};
        mem4.rsp_data  = d;
    endtask

    task automatic clear_inputs();
        eng4.req_valid = '0; eng4.req_addr = '0; eng4.req_tag = '0; eng4.rsp_ready = 4'hF;
        mem4.req_ready = 1'b1; mem4.rsp_valid = 1'b0; mem4.rsp_data = '0; mem4.rsp_tag = '0;
        eng3.req_valid = '0; eng3.req_addr = '0; eng3.req_tag = '0; eng3.rsp_ready = 3'h7;
        mem3.req_ready = 1'b1; mem3.rsp_valid = 1'b0; mem3.rsp_data = '0; mem3.rsp_tag = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Downstream request scoreboard: every accepted mem request must match the next expectation.
    always begin
        @(negedge clk);
        #2;
        if (mem4.req_valid === 1'b1 && mem4.req_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", {mem4.req_addr, mem4.req_tag}, 38'h0);
            end else begin
                sb_exp = exp_q.pop_front();
                check("mem_req", {mem4.req_addr, mem4.req_tag}, sb_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        eng4.req_valid = 4'hF;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_mem_valid", mem4.req_valid, 1'b0);
        check("rst_req_ready", eng4.req_ready, 4'h0);
        check("rst_idle", idle4, 1'b1);
        check("rst_err", err4, 1'b0);
        eng4.req_valid = '0;
        reset = 1'b0;

        // Single request and its response.
        set_req(0, 32'h1000, 4'd3);
        @(negedge clk); eng4.req_valid = 4'b0001; #1;
        check("t1_ready", eng4.req_ready, 4'b0001);
        push_exp(0);
        @(negedge clk); eng4.req_valid = 4'b0000; #1;
        check("t1_mem_valid", mem4.req_valid, 1'b1);
        check("t1_busy", idle4, 1'b0);
        @(negedge clk); rsp4(1'b1, 0, 4'd3, {8{32'hABABABAB}}); #1;
        check("t1_rsp_valid", eng4.rsp_valid, 4'b0001);
        check("t1_rsp_tag", eng4.rsp_tag, 4'd3);
        check("t1_rsp_data", eng4.rsp_data, {8{32'hABABABAB}});
        check("t1_mem_rsp_ready", mem4.rsp_ready, 1'b1);
        @(negedge clk); rsp4(1'b0, 0, 4'd0, '0); #1;
        check("t1_idle", idle4, 1'b1);

        // All requesters valid, responses echoed straight back: strict 0,1,2,3 rotation.
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 32'h2000 + 32'(i * 32), 4'(8 + i));
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            eng4.req_valid = 4'hF;
            rsp4(mem4.req_valid, 0, 4'd0, {224'h0, mem4.req_addr});
            mem4.rsp_tag = mem4.req_tag;
            #1;
            check("t2_grant", eng4.req_ready, 4'b0001 << (k % 4));
            push_exp(k % 4);
            if (k > 0) check("t2_rsp_route", eng4.rsp_valid, 4'b0001 << ((k - 1) % 4));
        end
        @(negedge clk);
        eng4.req_valid = '0;
        rsp4(mem4.req_valid, 0, 4'd0, '0);
        mem4.rsp_tag = mem4.req_tag;
        @(negedge clk); rsp4(1'b0, 0, 4'd0, '0); #1;
        check("t2_idle", idle4, 1'b1);

        // Credit exhaustion on requester 1, then release by a response.
        do_reset();
        set_req(1, 32'h3100, 4'd1);
        set_req(2, 32'h3200, 4'd2);
        @(negedge clk); eng4.req_valid = 4'b0010; #1;
        check("t3_g1a", eng4.req_ready, 4'b0010); push_exp(1);
        @(negedge clk); #1;
        check("t3_g1b", eng4.req_ready, 4'b0010); push_exp(1);
        @(negedge clk); eng4.req_valid = 4'b0110; #1;
        check("t3_g2_blocked1", eng4.req_ready, 4'b0100); push_exp(2);
        @(negedge clk); eng4.req_valid = 4'b0010; rsp4(1'b1, 1, 4'd1, 256'h11); #1;
        check("t3_no_credit", eng4.req_ready, 4'b0000);
        check("t3_rsp1", eng4.rsp_valid, 4'b0010);
        @(negedge clk); rsp4(1'b0, 0, 4'd0, '0); #1;
        check("t3_regrant1", eng4.req_ready, 4'b0010); push_exp(1);
        @(negedge clk); eng4.req_valid = '0;

        // Downstream stall: output register holds, no grants, then resumes with requester 2.
        do_reset();
        set_req(0, 32'h4000, 4'd5);
        set_req(2, 32'h4200, 4'd6);
        mem4.req_ready = 1'b0;
        @(negedge clk); eng4.req_valid = 4'b0101; #1;
        check("t4_first", eng4.req_ready, 4'b0001); push_exp(0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            check("t4_stall_ready", eng4.req_ready, 4'b0000);
            check("t4_stall_valid", mem4.req_valid, 1'b1);
            check("t4_stall_hold", {mem4.req_addr, mem4.req_tag}, {32'h4000, 2'd0, 4'd5});
        end
        @(negedge clk); mem4.req_ready = 1'b1; #1;
        check("t4_resume", eng4.req_ready, 4'b0100); push_exp(2);
        @(negedge clk); eng4.req_valid = '0; #1;
        check("t4_last_valid", mem4.req_valid, 1'b1);

        // Same-cycle grant and response keeps the count; a response at zero saturates.
        do_reset();
        set_req(0, 32'h5000, 4'd7);
        set_req(3, 32'h5300, 4'd9);
        @(negedge clk); eng4.req_valid = 4'b0001; #1;
        check("t5_g0a", eng4.req_ready, 4'b0001); push_exp(0);
        @(negedge clk); rsp4(1'b1, 0, 4'd7, 256'h7); #1;
        check("t5_g0_same", eng4.req_ready, 4'b0001); push_exp(0);
        check("t5_rsp0", eng4.rsp_valid, 4'b0001);
        @(negedge clk); rsp4(1'b0, 0, 4'd0, '0); #1;
        check("t5_g0c", eng4.req_ready, 4'b0001); push_exp(0);
        @(negedge clk); #1;
        check("t5_g0_full", eng4.req_ready, 4'b0000);
        @(negedge clk); eng4.req_valid = '0; rsp4(1'b1, 3, 4'd9, 256'h9); #1;
        check("t5_rsp3_zero", eng4.rsp_valid, 4'b1000);
        @(negedge clk); eng4.req_valid = 4'b1000; rsp4(1'b0, 0, 4'd0, '0); #1;
        check("t5_g3a", eng4.req_ready, 4'b1000); push_exp(3);
        @(negedge clk); #1;
        check("t5_g3b", eng4.req_ready, 4'b1000); push_exp(3);
        @(negedge clk); #1;
        check("t5_g3_full", eng4.req_ready, 4'b0000);
        @(negedge clk); eng4.req_valid = '0;

        // Three requesters: out-of-range rid, demux ready, credits and mid-operation reset.
        do_reset();
        @(negedge clk); mem3.rsp_valid = 1'b1; mem3.rsp_tag = {2'd3, 4'd5}; eng3.rsp_ready = 3'b000; #1;
        check("t6_bad_no_valid", eng3.rsp_valid, 3'b000);
        check("t6_bad_ready", mem3.rsp_ready, 1'b1);
        check("t6_err_pre", err3, 1'b0);
        @(negedge clk); mem3.rsp_tag = {2'd2, 4'd1}; eng3.rsp_ready = 3'b100; #1;
        check("t6_err_set", err3, 1'b1);
        check("t6_rid2_valid", eng3.rsp_valid, 3'b100);
        check("t6_rid2_ready", mem3.rsp_ready, 1'b1);
        @(negedge clk); eng3.rsp_ready = 3'b011; #1;
        check("t6_rid2_stall", mem3.rsp_ready, 1'b0);
        @(negedge clk); mem3.rsp_valid = 1'b0; eng3.rsp_ready = 3'b111;
        eng3.req_addr[64 +: 32] = 32'h6200; eng3.req_tag[8 +: 4] = 4'hC; eng3.req_valid = 3'b100; #1;
        check("t6_err_sticky", err3, 1'b1);
        check("t6_g2a", eng3.req_ready, 3'b100);
        @(negedge clk); #1;
        check("t6_g2b", eng3.req_ready, 3'b100);
        check("t6_mem_tag", {mem3.req_addr, mem3.req_tag}, {32'h6200, 2'd2, 4'hC});
        @(negedge clk); mem3.req_ready = 1'b0; #1;
        check("t6_g2_full", eng3.req_ready, 3'b000);
        check("t6_busy", idle3, 1'b0);
        @(negedge clk); reset = 1'b1; #1;
        check("t6_rst_ready", eng3.req_ready, 3'b000);
        @(negedge clk); #1;
        check("t6_rst_idle", idle3, 1'b1);
        check("t6_rst_mem_valid", mem3.req_valid, 1'b0);
        check("t6_rst_err", err3, 1'b0);
        @(negedge clk); reset = 1'b0; #1;
        check("t6_post_rst_grant", eng3.req_ready, 3'b100);
        @(negedge clk); eng3.req_valid = '0;
        @(negedge clk); #1;

        check("sb_leftover", 256'(exp_q.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
